// File: rtl/wb_pkg.sv
// Shared encodings for the handshaked writeback unit:
// result sources, load funct3 codes and FSM states.
package wb_pkg;

  localparam int unsigned SRC_ALU  = 0;
  localparam int unsigned SRC_LOAD = 1;
  localparam int unsigned SRC_PC4  = 2;
  localparam int unsigned SRC_AUX  = 3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: shifts the addressed lane down,
// sign/zero-extends by funct3 and flags misaligned accesses.
// Ports: i rdata/offset/funct3 -> o data, misaligned.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = 2
) (
  input  logic [XLEN-1:0]  rdata,
  input  logic [OFF_W-1:0] offset,
  input  logic [2:0]       funct3,
  output logic [XLEN-1:0]  data,
  output logic             misaligned
);

  logic [XLEN-1:0] w_sh;

  assign w_sh = rdata >> {offset, 3'b000};

  always_comb begin
    data       = w_sh;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  data = XLEN'($signed(w_sh[7:0]));
      F3_LBU: data = XLEN'(w_sh[7:0]);
      F3_LH: begin
        data       = XLEN'($signed(w_sh[15:0]));
        misaligned = offset[0];
      end
      F3_LHU: begin
        data       = XLEN'(w_sh[15:0]);
        misaligned = offset[0];
      end
      F3_LW: begin
        data       = XLEN'($signed(w_sh[31:0]));
        misaligned = |offset[1:0];
      end
      F3_LD: begin
        // Doubleword only exists on a 64-bit datapath.
        if (XLEN == 64) misaligned = |offset;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/writeback_unit_hs.sv
// Writeback stage with MEM handshake, load wait state, load
// alignment, registered regfile write port and retire counter.
// Ports: MEM-side in_valid/in_ready + instr fields, dmem
// response, regfile write (we/rd/result), misalign_err, count.
module writeback_unit_hs
  import wb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC),
  parameter int RA_W    = 5,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             reg_write_in,
  input  logic [SEL_W-1:0] result_src_in,
  input  logic [2:0]       load_funct3,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  pc_plus4,
  input  logic [XLEN-1:0]  aux_result,
  input  logic [RA_W-1:0]  rd_in,
  input  logic             dmem_rvalid,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             reg_write_out,
  output logic [RA_W-1:0]  rd_out,
  output logic [XLEN-1:0]  result_out,
  output logic             misalign_err,
  output logic [CNT_W-1:0] retire_count
);

  localparam int OFF_W = (XLEN == 64) ? 3 : 2;

  wb_state_e r_state, w_next;

  logic [RA_W-1:0]  r_h_rd;
  logic [2:0]       r_h_f3;
  logic [OFF_W-1:0] r_h_off;
  logic             r_h_we;

  logic             r_we, r_mis;
  logic [RA_W-1:0]  r_rd;
  logic [XLEN-1:0]  r_res;
  logic [CNT_W-1:0] r_cnt;

  logic             w_wait, w_acc, w_is_load;
  logic [OFF_W-1:0] w_al_off;
  logic [2:0]       w_al_f3;
  logic [XLEN-1:0]  w_al_data, w_src, w_wdata;
  logic             w_al_mis;
  logic             w_ld_now, w_go_wait, w_wait_done;
  logic             w_done, w_mis, w_we_req;
  logic [RA_W-1:0]  w_rd;

  assign w_wait    = (r_state == ST_WAIT);
  assign w_acc     = in_valid & in_ready;
  assign w_is_load = (result_src_in == SEL_W'(SRC_LOAD));

  // While waiting, align with the captured offset/funct3.
  assign w_al_off = w_wait ? r_h_off : alu_result[OFF_W-1:0];
  assign w_al_f3  = w_wait ? r_h_f3  : load_funct3;

  load_align #(.XLEN(XLEN), .OFF_W(OFF_W)) u_align (
    .rdata     (dmem_rdata),
    .offset    (w_al_off),
    .funct3    (w_al_f3),
    .data      (w_al_data),
    .misaligned(w_al_mis)
  );

  // A misaligned load never waits for memory.
  assign w_ld_now    = w_acc & w_is_load & (w_al_mis | dmem_rvalid);
  assign w_go_wait   = w_acc & w_is_load & ~w_al_mis & ~dmem_rvalid;
  assign w_wait_done = w_wait & dmem_rvalid;
  assign w_mis       = w_acc & w_is_load & w_al_mis;

  assign w_done = (w_acc & ~w_is_load) | w_ld_now | w_wait_done;

  assign w_rd     = w_wait ? r_h_rd : rd_in;
  assign w_we_req = (w_wait ? r_h_we : reg_write_in)
                  & (w_rd != '0) & w_done & ~w_mis;

  always_comb begin
    w_src = '0;
    case (result_src_in)
      SEL_W'(SRC_ALU): w_src = alu_result;
      SEL_W'(SRC_PC4): w_src = pc_plus4;
      SEL_W'(SRC_AUX): begin
        if (NUM_SRC > SRC_AUX) w_src = aux_result;
      end
      default: ;
    endcase
  end

  assign w_wdata = (w_wait | w_is_load) ? w_al_data : w_src;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_go_wait)   w_next = ST_WAIT;
      ST_WAIT: if (dmem_rvalid) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h_rd  <= '0;
      r_h_f3  <= '0;
      r_h_off <= '0;
      r_h_we  <= 1'b0;
    end else if (w_go_wait) begin
      r_h_rd  <= rd_in;
      r_h_f3  <= load_funct3;
      r_h_off <= alu_result[OFF_W-1:0];
      r_h_we  <= reg_write_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we  <= 1'b0;
      r_mis <= 1'b0;
      r_rd  <= '0;
      r_res <= '0;
      r_cnt <= '0;
    end else begin
      r_we  <= w_we_req;
      r_mis <= w_mis;
      if (w_we_req) begin
        r_rd  <= w_rd;
        r_res <= w_wdata;
      end
      if (w_done) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign reg_write_out = r_we;
  assign rd_out        = r_rd;
  assign result_out    = r_res;
  assign misalign_err  = r_mis;
  assign retire_count  = r_cnt;

endmodule

// File: tb/tb_writeback_unit_hs.sv
// Directed bench for writeback_unit_hs: ALU/PC4/aux writes,
// delayed and same-cycle loads, misalign, x0, reset, streaming.
module tb_writeback_unit_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, reg_write_in;
  logic [1:0]  result_src_in;
  logic [2:0]  load_funct3;
  logic [31:0] alu_result, pc_plus4, aux_result;
  logic [4:0]  rd_in;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        reg_write_out;
  logic [4:0]  rd_out;
  logic [31:0] result_out;
  logic        misalign_err;
  logic [31:0] retire_count;

  int checks = 0;
  int errors = 0;

  writeback_unit_hs dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .reg_write_in (reg_write_in),
    .result_src_in(result_src_in),
    .load_funct3  (load_funct3),
    .alu_result   (alu_result),
    .pc_plus4     (pc_plus4),
    .aux_result   (aux_result),
    .rd_in        (rd_in),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .reg_write_out(reg_write_out),
    .rd_out       (rd_out),
    .result_out   (result_out),
    .misalign_err (misalign_err),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid      = 1'b0;
    reg_write_in  = 1'b0;
    result_src_in = 2'd0;
    load_funct3   = 3'd0;
    alu_result    = '0;
    pc_plus4      = '0;
    aux_result    = '0;
    rd_in         = '0;
    dmem_rvalid   = 1'b0;
    dmem_rdata    = '0;
  endtask

  task automatic issue(input logic [1:0]  src,
                       input logic [2:0]  f3,
                       input logic [31:0] alu,
                       input logic [4:0]  rd,
                       input logic        rv,
                       input logic [31:0] rdat);
    in_valid      = 1'b1;
    reg_write_in  = 1'b1;
    result_src_in = src;
    load_funct3   = f3;
    alu_result    = alu;
    rd_in         = rd;
    dmem_rvalid   = rv;
    dmem_rdata    = rdat;
  endtask

  initial begin
    idle_in();
    rst = 1'b0;
    step();
    step();
    chk("rst_we",   64'(reg_write_out), 64'd0);
    chk("rst_rd",   64'(rd_out),        64'd0);
    chk("rst_res",  64'(result_out),    64'd0);
    chk("rst_mis",  64'(misalign_err),  64'd0);
    chk("rst_cnt",  64'(retire_count),  64'd0);
    chk("rst_rdy",  64'(in_ready),      64'd1);
    rst = 1'b1;
    step();

    // 1: ALU op
    issue(2'd0, 3'd0, 32'h1234, 5'd5, 1'b0, '0);
    step();
    chk("alu_we",  64'(reg_write_out), 64'd1);
    chk("alu_rd",  64'(rd_out),        64'd5);
    chk("alu_res", 64'(result_out),    64'h1234);
    chk("alu_cnt", 64'(retire_count),  64'd1);
    idle_in();
    step();
    chk("hold_we",  64'(reg_write_out), 64'd0);
    chk("hold_res", 64'(result_out),    64'h1234);

    // 2: x0 destination, PC+4 source
    issue(2'd2, 3'd0, 32'h0, 5'd0, 1'b0, '0);
    pc_plus4 = 32'h40;
    step();
    chk("x0_we",  64'(reg_write_out), 64'd0);
    chk("x0_cnt", 64'(retire_count),  64'd2);
    chk("x0_res", 64'(result_out),    64'h1234);
    idle_in();

    // 3: LB offset 3, response 4 cycles late
    issue(2'd1, 3'b000, 32'h1003, 5'd7, 1'b0, '0);
    step();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      chk("dly_rdy", 64'(in_ready),      64'd0);
      chk("dly_we",  64'(reg_write_out), 64'd0);
      if (i == 3) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h80FF_FFFF;
      end
      step();
    end
    idle_in();
    chk("dly_we1", 64'(reg_write_out), 64'd1);
    chk("dly_res", 64'(result_out),    64'hFFFF_FF80);
    chk("dly_rd",  64'(rd_out),        64'd7);
    chk("dly_cnt", 64'(retire_count),  64'd3);
    chk("dly_rdy1",64'(in_ready),      64'd1);

    // stray rvalid in IDLE is ignored
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hAAAA_AAAA;
    step();
    idle_in();
    chk("stray_we",  64'(reg_write_out), 64'd0);
    chk("stray_cnt", 64'(retire_count),  64'd3);

    // 4: LHU offset 2, same-cycle data
    issue(2'd1, 3'b101, 32'h2, 5'd9, 1'b1, 32'hBEEF_0000);
    step();
    chk("lhu_we",  64'(reg_write_out), 64'd1);
    chk("lhu_res", 64'(result_out),    64'h0000_BEEF);
    chk("lhu_rdy", 64'(in_ready),      64'd1);
    chk("lhu_cnt", 64'(retire_count),  64'd4);

    issue(2'd1, 3'b001, 32'h2, 5'd10, 1'b1, 32'h8001_0000);
    step();
    chk("lh_res", 64'(result_out), 64'hFFFF_8001);
    issue(2'd1, 3'b100, 32'h1, 5'd11, 1'b1, 32'h0000_9A00);
    step();
    chk("lbu_res", 64'(result_out), 64'h0000_009A);
    issue(2'd1, 3'b010, 32'h0, 5'd12, 1'b1, 32'hDEAD_BEEF);
    step();
    chk("lw_res", 64'(result_out),   64'hDEAD_BEEF);
    chk("lw_cnt", 64'(retire_count), 64'd7);

    // 5: misaligned LW, no memory response
    issue(2'd1, 3'b010, 32'h1, 5'd3, 1'b0, '0);
    step();
    chk("mis_err", 64'(misalign_err),  64'd1);
    chk("mis_we",  64'(reg_write_out), 64'd0);
    chk("mis_rdy", 64'(in_ready),      64'd1);
    chk("mis_cnt", 64'(retire_count),  64'd8);
    chk("mis_res", 64'(result_out),    64'hDEAD_BEEF);
    issue(2'd1, 3'b001, 32'h3, 5'd3, 1'b0, '0);
    step();
    chk("mish_err", 64'(misalign_err), 64'd1);
    idle_in();
    step();
    chk("mis_pulse", 64'(misalign_err), 64'd0);

    // aux source
    issue(2'd3, 3'd0, 32'h0, 5'd4, 1'b0, '0);
    aux_result = 32'h55AA;
    step();
    chk("aux_res", 64'(result_out),   64'h55AA);
    chk("aux_cnt", 64'(retire_count), 64'd10);
    idle_in();

    // 6: reset while waiting for a load
    issue(2'd1, 3'b000, 32'h0, 5'd8, 1'b0, '0);
    step();
    idle_in();
    chk("rw_rdy0", 64'(in_ready), 64'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("rw_cnt",  64'(retire_count), 64'd0);
    chk("rw_rdy",  64'(in_ready),     64'd1);
    step();
    rst = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h7F;
    step();
    idle_in();
    chk("rw_we",   64'(reg_write_out), 64'd0);
    chk("rw_cnt1", 64'(retire_count),  64'd0);
    chk("rw_res",  64'(result_out),    64'd0);
    chk("rw_rdy1", 64'(in_ready),      64'd1);

    // 7: back-to-back ALU ops
    for (int i = 0; i < 4; i++) begin
      issue(2'd0, 3'd0, 32'h100 + 32'(i), 5'(i + 1), 1'b0, '0);
      chk("b2b_rdy", 64'(in_ready), 64'd1);
      step();
      chk("b2b_we",  64'(reg_write_out), 64'd1);
      chk("b2b_res", 64'(result_out),    64'(32'h100 + 32'(i)));
      chk("b2b_rd",  64'(rd_out),        64'(i + 1));
      chk("b2b_cnt", 64'(retire_count),  64'(i + 1));
    end
    idle_in();
    step();
    chk("b2b_end", 64'(reg_write_out), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
